// File: rtl/grover_pkg.sv
// Shared definitions for the Grover diffusion datapath: FSM states and Q1.22 amplitude constants.
package grover_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    ACCUM   = 3'd1,
    MEAN    = 3'd2,
    REFLECT = 3'd3,
    DONE    = 3'd4
  } state_e;

  localparam int Q_BITS = 24;
  localparam logic signed [Q_BITS-1:0] Q_ONE = 24'sh400000;
  localparam logic signed [Q_BITS-1:0] Q_MAX = 24'sh7FFFFF;
  localparam logic signed [Q_BITS-1:0] Q_MIN = 24'sh800000;

endpackage

// File: rtl/grover_reflect_sat.sv
// Inversion about the mean for one amplitude: y = sat(2*mean - x), purely combinational.
// Evaluated W+2 bits wide so neither the doubling nor the subtraction can wrap before clamping.
module grover_reflect_sat
  import grover_pkg::*;
#(
  parameter int W = 24
) (
  input  logic signed [W-1:0] mean,
  input  logic signed [W-1:0] x,
  output logic signed [W-1:0] y
);

  localparam logic signed [W-1:0] SAT_MAX = (W == Q_BITS) ? W'(Q_MAX) : {1'b0, {(W-1){1'b1}}};
  localparam logic signed [W-1:0] SAT_MIN = (W == Q_BITS) ? W'(Q_MIN) : {1'b1, {(W-1){1'b0}}};

  logic signed [W+1:0] mean_e;
  logic signed [W+1:0] x_e;
  logic signed [W+1:0] diff;
  logic signed [W+1:0] max_e;
  logic signed [W+1:0] min_e;

  always_comb begin
    mean_e = (W+2)'(mean);
    x_e    = (W+2)'(x);
    max_e  = (W+2)'(SAT_MAX);
    min_e  = (W+2)'(SAT_MIN);
    diff   = (mean_e <<< 1) - x_e;
    if (diff > max_e) begin
      y = SAT_MAX;
    end else if (diff < min_e) begin
      y = SAT_MIN;
    end else begin
      y = diff[W-1:0];
    end
  end

endmodule

// File: rtl/grover_diffusion_seq.sv
// Sequential Grover diffusion: captures a state vector, averages it, then writes 2*mean - x[i] one entry per cycle.
// Latency: done pulses 2*num_sample+2 cycles after start is sampled; start is ignored while busy (no other backpressure).
module grover_diffusion_seq
  import grover_pkg::*;
#(
  parameter int num_bit        = 3,
  parameter int fixedpoint_bit = 24,
  parameter int num_sample     = 2**num_bit
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             start,
  input  logic signed [fixedpoint_bit-1:0] diffusion_in  [0:num_sample-1],
  output logic                             busy,
  output logic                             done,
  output logic signed [fixedpoint_bit-1:0] diffusion_out [0:num_sample-1]
);

  localparam int IW = (num_sample > 1) ? $clog2(num_sample) : 1;
  localparam int AW = fixedpoint_bit + num_bit;
  localparam logic [IW-1:0] LAST_IDX = IW'(num_sample - 1);

  state_e                           state_q, state_d;
  logic        [IW-1:0]             idx_q, idx_d;
  logic signed [AW-1:0]             acc_q, acc_d;
  logic signed [fixedpoint_bit-1:0] mean_q, mean_d;
  logic signed [fixedpoint_bit-1:0] buf_q [0:num_sample-1];
  logic signed [fixedpoint_bit-1:0] buf_d [0:num_sample-1];
  logic signed [fixedpoint_bit-1:0] out_q [0:num_sample-1];
  logic signed [fixedpoint_bit-1:0] out_d [0:num_sample-1];
  logic signed [fixedpoint_bit-1:0] refl_y;

  grover_reflect_sat #(
    .W (fixedpoint_bit)
  ) u_reflect_sat (
    .mean (mean_q),
    .x    (buf_q[idx_q]),
    .y    (refl_y)
  );

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    acc_d   = acc_q;
    mean_d  = mean_q;
    buf_d   = buf_q;
    out_d   = out_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          buf_d   = diffusion_in;
          acc_d   = '0;
          idx_d   = '0;
          state_d = ACCUM;
        end
      end
      ACCUM: begin
        acc_d = acc_q + AW'(buf_q[idx_q]);
        if (idx_q == LAST_IDX) begin
          idx_d   = '0;
          state_d = MEAN;
        end else begin
          idx_d = idx_q + IW'(1);
        end
      end
      MEAN: begin
        // Arithmetic shift floors toward minus infinity, matching the fixed-point divide by num_sample.
        mean_d  = fixedpoint_bit'(acc_q >>> num_bit);
        idx_d   = '0;
        state_d = REFLECT;
      end
      REFLECT: begin
        out_d[idx_q] = refl_y;
        if (idx_q == LAST_IDX) begin
          idx_d   = '0;
          state_d = DONE;
        end else begin
          idx_d = idx_q + IW'(1);
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      idx_q   <= '0;
      acc_q   <= '0;
      mean_q  <= '0;
      for (int i = 0; i < num_sample; i++) begin
        buf_q[i] <= '0;
        out_q[i] <= '0;
      end
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      acc_q   <= acc_d;
      mean_q  <= mean_d;
      buf_q   <= buf_d;
      out_q   <= out_d;
    end
  end

  assign busy          = (state_q != IDLE);
  assign done          = (state_q == DONE);
  assign diffusion_out = out_q;

endmodule

// File: tb/tb_grover_diffusion_seq.sv
// Scoreboard bench for grover_diffusion_seq: expected vectors queued at launch, checked when done pulses.
module tb_grover_diffusion_seq;

  localparam int NB = 3;
  localparam int FB = 24;
  localparam int NS = 8;

  typedef logic [NS-1:0][FB-1:0] pvec_t;

  logic                 clk;
  logic                 rst_n;
  logic                 start;
  logic signed [FB-1:0] din  [0:NS-1];
  logic                 busy;
  logic                 done;
  logic signed [FB-1:0] dout [0:NS-1];

  int    total;
  int    bad;
  int    cyc_abs;
  pvec_t exp_q [$];

  grover_diffusion_seq #(
    .num_bit        (NB),
    .fixedpoint_bit (FB),
    .num_sample     (NS)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .start         (start),
    .diffusion_in  (din),
    .busy          (busy),
    .done          (done),
    .diffusion_out (dout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc_abs = 0;
  always @(posedge clk) cyc_abs <= cyc_abs + 1;

  function automatic pvec_t model(input pvec_t v);
    pvec_t  r;
    longint s;
    longint m;
    longint d;
    s = 0;
    for (int i = 0; i < NS; i++) s += longint'($signed(v[i]));
    m = s >>> NB;
    for (int i = 0; i < NS; i++) begin
      d = 2 * m - longint'($signed(v[i]));
      if (d > 64'sd8388607) d = 64'sd8388607;
      if (d < -64'sd8388608) d = -64'sd8388608;
      r[i] = d[FB-1:0];
    end
    return r;
  endfunction

  function automatic pvec_t fill(input logic [FB-1:0] val);
    pvec_t r;
    for (int i = 0; i < NS; i++) r[i] = val;
    return r;
  endfunction

  // Called at posedge+1; returns at posedge+1 of the first cycle of the pass (cycle 1).
  task automatic launch(input pvec_t v);
    for (int i = 0; i < NS; i++) din[i] = v[i];
    start = 1'b1;
    exp_q.push_back(model(v));
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic wait_done(input int c0, output int c);
    c = c0;
    while (done !== 1'b1 && c < 60) begin
      @(posedge clk);
      #1;
      c++;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    start = 1'b0;
    for (int i = 0; i < NS; i++) din[i] = '0;
    #23;
    total++;
    if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b want=0", busy); end
    total++;
    if (done !== 1'b0) begin bad++; $display("FAIL reset_done got=%b want=0", done); end
    for (int i = 0; i < NS; i++) begin
      total++;
      if (dout[i] !== '0) begin bad++; $display("FAIL reset_out[%0d] got=%0d want=0", i, dout[i]); end
    end
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_uniform();
    pvec_t e;
    int    c;
    launch(fill(24'h16A09E));
    total++;
    if (busy !== 1'b1) begin bad++; $display("FAIL uniform_busy got=%b want=1", busy); end
    wait_done(1, c);
    total++;
    if (c != 18) begin bad++; $display("FAIL uniform_latency got=%0d want=18", c); end
    total++;
    if (busy !== 1'b1) begin bad++; $display("FAIL uniform_busy_done got=%b want=1", busy); end
    e = exp_q.pop_front();
    for (int i = 0; i < NS; i++) begin
      total++;
      if (dout[i] !== $signed(e[i]) || dout[i] !== 24'sd1482910) begin
        bad++; $display("FAIL uniform_out[%0d] got=%0d want=1482910", i, dout[i]);
      end
    end
    @(posedge clk);
    #1;
    total++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      bad++; $display("FAIL uniform_after got done=%b busy=%b want 0 0", done, busy);
    end
  endtask

  task automatic test_one_negated();
    pvec_t v;
    pvec_t e;
    int    c;
    v    = fill(24'h16A09E);
    v[5] = -24'sd1482910;
    launch(v);
    wait_done(1, c);
    total++;
    if (c != 18) begin bad++; $display("FAIL negated_latency got=%0d want=18", c); end
    e = exp_q.pop_front();
    total++;
    if (dout[5] !== 24'sd3707274) begin bad++; $display("FAIL negated_out5 got=%0d want=3707274", dout[5]); end
    for (int i = 0; i < NS; i++) begin
      total++;
      if (dout[i] !== $signed(e[i])) begin
        bad++; $display("FAIL negated_out[%0d] got=%0d want=%0d", i, dout[i], $signed(e[i]));
      end
    end
    total++;
    if (dout[2] !== 24'sd741454) begin bad++; $display("FAIL negated_out2 got=%0d want=741454", dout[2]); end
    @(posedge clk);
    #1;
  endtask

  task automatic test_saturate();
    pvec_t v;
    pvec_t e;
    int    c;
    v    = fill(24'h7FFFFF);
    v[0] = 24'h800000;
    launch(v);
    wait_done(1, c);
    total++;
    if (c != 18) begin bad++; $display("FAIL sat_latency got=%0d want=18", c); end
    e = exp_q.pop_front();
    total++;
    if (dout[0] !== 24'sh7FFFFF) begin bad++; $display("FAIL sat_out0 got=%0d want=8388607", dout[0]); end
    total++;
    if (dout[7] !== 24'sd4194303) begin bad++; $display("FAIL sat_out7 got=%0d want=4194303", dout[7]); end
    for (int i = 0; i < NS; i++) begin
      total++;
      if (dout[i] !== $signed(e[i])) begin
        bad++; $display("FAIL sat_out[%0d] got=%0d want=%0d", i, dout[i], $signed(e[i]));
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_start_ignored();
    pvec_t v;
    pvec_t e;
    int    c;
    int    ndone;
    int    done_at;
    for (int i = 0; i < NS; i++) v[i] = FB'(i * 300000 - 1000000);
    launch(v);
    ndone   = 0;
    done_at = 0;
    e       = exp_q.pop_front();
    for (c = 1; c <= 30; c++) begin
      if (c == 3 || c == 10) begin
        start = 1'b1;
        for (int i = 0; i < NS; i++) din[i] = '0;
      end else begin
        start = 1'b0;
      end
      if (done === 1'b1) begin
        ndone++;
        done_at = c;
        for (int i = 0; i < NS; i++) begin
          total++;
          if (dout[i] !== $signed(e[i])) begin
            bad++; $display("FAIL ignore_out[%0d] got=%0d want=%0d", i, dout[i], $signed(e[i]));
          end
        end
      end
      @(posedge clk);
      #1;
    end
    start = 1'b0;
    total++;
    if (ndone != 1) begin bad++; $display("FAIL ignore_done_count got=%0d want=1", ndone); end
    total++;
    if (done_at != 18) begin bad++; $display("FAIL ignore_latency got=%0d want=18", done_at); end
  endtask

  task automatic test_reset_midpass();
    pvec_t v;
    pvec_t e;
    int    c;
    for (int i = 0; i < NS; i++) v[i] = FB'(i * 50000 + 20000);
    launch(v);
    for (c = 1; c < 12; c++) begin
      @(posedge clk);
      #1;
    end
    rst_n = 1'b0;
    #1;
    void'(exp_q.pop_front());
    total++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      bad++; $display("FAIL midreset_ctl got busy=%b done=%b want 0 0", busy, done);
    end
    for (int i = 0; i < NS; i++) begin
      total++;
      if (dout[i] !== '0) begin bad++; $display("FAIL midreset_out[%0d] got=%0d want=0", i, dout[i]); end
    end
    #5;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    for (int i = 0; i < NS; i++) v[i] = FB'(-(i * 70000) + 10000);
    launch(v);
    wait_done(1, c);
    total++;
    if (c != 18) begin bad++; $display("FAIL midreset_latency got=%0d want=18", c); end
    e = exp_q.pop_front();
    for (int i = 0; i < NS; i++) begin
      total++;
      if (dout[i] !== $signed(e[i])) begin
        bad++; $display("FAIL midreset_out2[%0d] got=%0d want=%0d", i, dout[i], $signed(e[i]));
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_back_to_back();
    pvec_t v;
    pvec_t e;
    int    c;
    int    t1;
    int    t2;
    for (int p = 0; p < 2; p++) begin
      for (int i = 0; i < NS; i++) v[i] = FB'($urandom);
      launch(v);
      wait_done(1, c);
      total++;
      if (c != 18) begin bad++; $display("FAIL b2b_latency[%0d] got=%0d want=18", p, c); end
      if (p == 0) t1 = cyc_abs;
      else        t2 = cyc_abs;
      e = exp_q.pop_front();
      for (int i = 0; i < NS; i++) begin
        total++;
        if (dout[i] !== $signed(e[i])) begin
          bad++; $display("FAIL b2b_out%0d[%0d] got=%0d want=%0d", p, i, dout[i], $signed(e[i]));
        end
      end
      @(posedge clk);
      #1;
    end
    total++;
    if (t2 - t1 != 19) begin bad++; $display("FAIL b2b_spacing got=%0d want=19", t2 - t1); end
  endtask

  initial begin
    total = 0;
    bad   = 0;
    test_reset();
    test_uniform();
    test_one_negated();
    test_saturate();
    test_start_ignored();
    test_reset_midpass();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
